// File: rtl/tpm_buf_arbiter.sv
// tpm_buf_arbiter: shares the TPM command/response RAM between the LPC data provider and the CPU Wishbone window
module tpm_buf_arbiter #(
    parameter int         ADDR_WIDTH      = 11,
    parameter logic [7:0] DP_REJECT_VALUE = 8'hFF
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  exec_i,
    output logic                  owner_o,
    input  logic                  dp_req_i,
    input  logic                  dp_we_i,
    input  logic [ADDR_WIDTH-1:0] dp_addr_i,
    input  logic [7:0]            dp_wdata_i,
    output logic [7:0]            dp_rdata_o,
    output logic                  dp_ack_o,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_we_i,
    input  logic [ADDR_WIDTH-3:0] wb_adr_i,
    input  logic [3:0]            wb_sel_i,
    input  logic [31:0]           wb_dat_i,
    output logic [31:0]           wb_dat_o,
    output logic                  wb_ack_o,
    output logic                  wb_err_o,
    output logic [ADDR_WIDTH-3:0] ram_addr_o,
    output logic [31:0]           ram_wdata_o,
    output logic [3:0]            ram_wen_o,
    input  logic [31:0]           ram_rdata_i,
    output logic                  busy_o
);
    localparam int WA = ADDR_WIDTH - 2;
    typedef enum logic [2:0] {IDLE, SWITCH, ISSUE, RESP, REJECT} state_t;
    state_t        state_q, state_d;
    logic          owner_q, owner_d, is_wb_q, is_wb_d;
    logic [1:0]    lane_q, lane_d;
    logic [WA-1:0] waddr_q, waddr_d, ram_addr_q, ram_addr_d;
    logic [31:0]   wdat_q, wdat_d, ram_wdata_q, ram_wdata_d, wb_dat_q, wb_dat_d;
    logic [3:0]    pwen_q, pwen_d, ram_wen_q, ram_wen_d;
    logic [7:0]    dp_rdata_q, dp_rdata_d;
    logic          dp_ack_q, dp_ack_d, wb_ack_q, wb_ack_d, wb_err_q, wb_err_d;
    logic          dp_pend, wb_pend, own_pend, oth_pend;
    // a request whose ack/err is still showing is the one just served, not a new one
    assign dp_pend  = dp_req_i & ~dp_ack_q;
    assign wb_pend  = wb_cyc_i & wb_stb_i & ~wb_ack_q & ~wb_err_q;
    assign own_pend = owner_q ? wb_pend : dp_pend;
    assign oth_pend = owner_q ? dp_pend : wb_pend;
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        is_wb_d     = is_wb_q;
        lane_d      = lane_q;
        waddr_d     = waddr_q;
        wdat_d      = wdat_q;
        pwen_d      = pwen_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_wen_d   = ram_wen_q;
        dp_rdata_d  = dp_rdata_q;
        wb_dat_d    = wb_dat_q;
        dp_ack_d    = 1'b0;
        wb_ack_d    = 1'b0;
        wb_err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (exec_i != owner_q) begin
                    state_d = SWITCH;
                end else if (own_pend) begin
                    state_d = ISSUE;
                    is_wb_d = owner_q;
                    lane_d  = dp_addr_i[1:0];
                    waddr_d = owner_q ? wb_adr_i : dp_addr_i[ADDR_WIDTH-1:2];
                    wdat_d  = owner_q ? wb_dat_i : {4{dp_wdata_i}};
                    pwen_d  = owner_q ? (wb_we_i ? wb_sel_i : 4'b0000)
                                      : (dp_we_i ? 4'b0001 << dp_addr_i[1:0] : 4'b0000);
                end else if (oth_pend) begin
                    state_d = REJECT;
                    is_wb_d = ~owner_q;
                end
            end
            SWITCH: begin
                owner_d = exec_i;
                state_d = IDLE;
            end
            ISSUE: begin
                ram_addr_d  = waddr_q;
                ram_wdata_d = wdat_q;
                ram_wen_d   = pwen_q;
                state_d     = RESP;
            end
            RESP: begin
                ram_wen_d  = 4'b0000;
                wb_dat_d   = is_wb_q ? ram_rdata_i : wb_dat_q;
                dp_rdata_d = is_wb_q ? dp_rdata_q : 8'(ram_rdata_i >> {lane_q, 3'b000});
                wb_ack_d   = is_wb_q;
                dp_ack_d   = ~is_wb_q;
                state_d    = IDLE;
            end
            REJECT: begin
                wb_dat_d   = is_wb_q ? 32'h0 : wb_dat_q;
                dp_rdata_d = is_wb_q ? dp_rdata_q : DP_REJECT_VALUE;
                wb_err_d   = is_wb_q;
                dp_ack_d   = ~is_wb_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            is_wb_q     <= 1'b0;
            lane_q      <= '0;
            waddr_q     <= '0;
            wdat_q      <= '0;
            pwen_q      <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_wen_q   <= '0;
            dp_rdata_q  <= '0;
            wb_dat_q    <= '0;
            dp_ack_q    <= 1'b0;
            wb_ack_q    <= 1'b0;
            wb_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            is_wb_q     <= is_wb_d;
            lane_q      <= lane_d;
            waddr_q     <= waddr_d;
            wdat_q      <= wdat_d;
            pwen_q      <= pwen_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_wen_q   <= ram_wen_d;
            dp_rdata_q  <= dp_rdata_d;
            wb_dat_q    <= wb_dat_d;
            dp_ack_q    <= dp_ack_d;
            wb_ack_q    <= wb_ack_d;
            wb_err_q    <= wb_err_d;
        end
    end
    assign owner_o     = owner_q;
    assign dp_rdata_o  = dp_rdata_q;
    assign dp_ack_o    = dp_ack_q;
    assign wb_dat_o    = wb_dat_q;
    assign wb_ack_o    = wb_ack_q;
    assign wb_err_o    = wb_err_q;
    assign ram_addr_o  = ram_addr_q;
    assign ram_wdata_o = ram_wdata_q;
    assign ram_wen_o   = ram_wen_q;
    assign busy_o      = state_q != IDLE;
endmodule

// File: doc/tpm_buf_arbiter.md
Name: tpm_buf_arbiter

Overview:
- Single-clock arbiter sharing the 512x32 TPM command/response RAM between the LPC-side data provider (byte port) and the CPU Wishbone slave window at 0xF0000800 (word port).
- Ownership follows exec: host/data provider owns the buffer while exec is low; CPU owns it while exec is high.
- The block sequences all RAM accesses through one registered port.
- It replaces the clock-muxed RAM sharing with a clean handshake on wb_clk; the data provider side is synchronised upstream.

Parameters:
- ADDR_WIDTH, 11, byte address width of the buffer (RAM word address = ADDR_WIDTH-2 bits).
- DP_REJECT_VALUE, 8'hFF, read data returned to a data-provider access rejected for ownership.

Ports:
- clk_i  in  1  clock (wb_clk domain).
- rstn_i  in  1  reset, synchronous, active-low.
- exec_i  in  1  ownership request: 1 = CPU owns, 0 = host owns.
- owner_o  out  1  current owner: 1 = CPU, 0 = host.
- dp_req_i  in  1  data-provider request, level, held until dp_ack_o.
- dp_we_i  in  1  data-provider write enable.
- dp_addr_i  in  ADDR_WIDTH  data-provider byte address.
- dp_wdata_i  in  8  data-provider write byte.
- dp_rdata_o  out  8  data-provider read byte, valid with dp_ack_o.
- dp_ack_o  out  1  one-cycle completion pulse.
- wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  Wishbone classic control.
- wb_adr_i  in  ADDR_WIDTH-2  Wishbone word address.
- wb_sel_i  in  4  byte enables.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data, valid with wb_ack_o.
- wb_ack_o  out  1  one-cycle ack.
- wb_err_o  out  1  one-cycle error; replaces ack.
- ram_addr_o  out  ADDR_WIDTH-2  RAM word address, registered.
- ram_wdata_o  out  32  RAM write data, registered.
- ram_wen_o  out  4  RAM byte write enables, registered. Bit i writes [8i+7:8i].
- ram_rdata_i  in  32  RAM read data; available 1 cycle after address.
- busy_o  out  1  high in every state except IDLE.

Behaviour:
- Reset (rstn_i low at a clk_i edge) forces the following, regardless of state or in-flight access:
  - state IDLE, owner_o=0
  - dp_ack_o, wb_ack_o, wb_err_o = 0
  - ram_wen_o=0, ram_addr_o=0, ram_wdata_o=0
  - dp_rdata_o=0, wb_dat_o=0
  - The aborted access gets no ack.
- States: IDLE, SWITCH, ISSUE, RESP, REJECT.
- IDLE:
  - Priority 1: if exec_i != owner_o, go to SWITCH; no request is accepted that cycle.
  - Else, owner request pending (DP: dp_req_i; WB: wb_cyc_i & wb_stb_i): latch op/address/data, go to ISSUE.
  - Else, non-owner request pending: go to REJECT.
  - Owner request beats non-owner when both are pending in the same cycle.
- SWITCH: owner_o <= exec_i, then go to IDLE. An exec_i change during an access therefore takes effect only after that access completes.
- ISSUE: drive RAM registers, then go to RESP.
  - DP access: ram_addr_o=dp_addr[ADDR_WIDTH-1:2].
  - DP write: wdata = byte replicated in all 4 lanes; wen = one-hot of dp_addr[1:0] (00→0001, 01→0010, 10→0100, 11→1000).
  - DP read: wen=0.
  - WB access: ram_addr_o=wb_adr_i, wdata=wb_dat_i, wen = wb_we_i ? wb_sel_i : 0.
- RESP:
  - ram_wen_o <= 0, so wen is high for exactly one cycle.
  - Capture ram_rdata_i. DP: dp_rdata_o = lane selected by addr[1:0]. WB: wb_dat_o = full word.
  - Pulse the requester's ack; go to IDLE.
  - Latency: request sampled in IDLE at edge N, ack high during cycle N+2 to N+3. Writes ack identically.
- REJECT: no RAM activity; go to IDLE.
  - DP: dp_ack_o pulse with dp_rdata_o=DP_REJECT_VALUE; write discarded.
  - WB: wb_err_o pulse (wb_ack_o stays 0), wb_dat_o=0.
- Requesters deassert in the cycle after their ack/err. IDLE following RESP/REJECT must not re-accept the same request; a request held past ack is a protocol violation (not checked).
- A WB cycle with wb_sel_i=0 on write still acks, with no RAM write.
- Address wrap is impossible (full width decoded); the top word is 511.
- dp_ack_o and wb_ack_o are never high in the same cycle. wb_ack_o and wb_err_o are mutually exclusive.

Test Plan:
- Reset then host writes: exec_i=0, DP write 0xA5 to byte addr 0x006 → ram_addr_o=1, ram_wen_o=0100 for one cycle, ram_wdata_o=0xA5A5A5A5, dp_ack_o 2 cycles after request.
- Ownership transfer: set exec_i=1 → owner_o=1 after 2 cycles. WB read word 1 (RAM model holds 0x00A50000) → wb_dat_o=0x00A50000, wb_ack_o at N+2.
- Ownership rejection: owner=CPU, DP read 0x010 → dp_ack_o at N+1, dp_rdata_o=0xFF, ram_wen_o stays 0. Owner=host, WB write → wb_err_o pulse, no ack, RAM unchanged.
- Same-cycle requests: owner=CPU, DP and WB requests in the same cycle → WB served (ack N+2), then DP rejected (ack N+4).
- exec change during access: exec_i falls in ISSUE of a WB write with sel=1111 → write completes with wb_ack_o, then SWITCH, owner_o=0.
- Reset during ISSUE of a write → next cycle ram_wen_o=0, no ack, owner_o=0, busy_o=0.
